// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, response type and the
// byte-address to register-word-index helper.
package axi_lite_pkg;

    localparam int AXI_MAX_AW = 32;
    localparam int AXI_IDX_W  = AXI_MAX_AW - 2;

    typedef logic [1:0] axi_lite_resp_t;

    localparam axi_lite_resp_t RESP_OKAY   = 2'b00;
    localparam axi_lite_resp_t RESP_SLVERR = 2'b10;

    // Callers zero-extend their ADDR_WIDTH address, so the result equals
    // addr[ADDR_WIDTH-1:2]; addr[1:0] is dropped.
    function automatic logic [AXI_IDX_W-1:0] addr_to_idx(input logic [AXI_MAX_AW-1:0] addr);
        return addr[AXI_MAX_AW-1:2];
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    axi_lite_resp_t            b_resp;

    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    axi_lite_resp_t            r_resp;

    modport master (
        output aw_valid, aw_addr, input  aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input  b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, input ar_ready,
        input  r_valid, r_data, r_resp, output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input  ar_valid, ar_addr, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );

endinterface

// File: rtl/axi_lite_reg_slave.sv
// Terminal AXI-Lite slave exposing NUM_REGS byte-strobed registers, with
// decoupled AW/W capture, single-slot B and a one-deep read pipeline.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 8,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_lite_if.slave                      s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

    logic                  aw_held_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_held_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  b_valid_q;
    axi_lite_resp_t        b_resp_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    axi_lite_resp_t        r_resp_q;

    logic [AXI_IDX_W-1:0]  aw_idx, ar_idx;
    logic                  aw_in_range, ar_in_range;
    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  commit;
    logic [DATA_WIDTH-1:0] rd_data;

    assign s_axi.aw_ready = !aw_held_q && !rst;
    assign s_axi.w_ready  = !w_held_q  && !rst;
    assign s_axi.ar_ready = !r_valid_q && !rst;
    assign s_axi.b_valid  = b_valid_q;
    assign s_axi.b_resp   = b_resp_q;
    assign s_axi.r_valid  = r_valid_q;
    assign s_axi.r_data   = r_data_q;
    assign s_axi.r_resp   = r_resp_q;

    assign aw_hs = s_axi.aw_valid && s_axi.aw_ready;
    assign w_hs  = s_axi.w_valid  && s_axi.w_ready;
    assign ar_hs = s_axi.ar_valid && s_axi.ar_ready;
    assign b_hs  = b_valid_q && s_axi.b_ready;
    assign r_hs  = r_valid_q && s_axi.r_ready;

    assign aw_idx      = addr_to_idx(AXI_MAX_AW'(aw_addr_q));
    assign ar_idx      = addr_to_idx(AXI_MAX_AW'(s_axi.ar_addr));
    assign aw_in_range = aw_idx < AXI_IDX_W'(NUM_REGS);
    assign ar_in_range = ar_idx < AXI_IDX_W'(NUM_REGS);

    // A held pair may only retire once the single B slot is empty.
    assign commit = aw_held_q && w_held_q && !b_valid_q && !rst;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && aw_idx == AXI_IDX_W'(i)) begin
                wr_pulse_o[i] = 1'b1;
                for (int k = 0; k < STRB_W; k++) begin
                    if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
                end
            end
        end
    end

    // Read mux looks at regs_q, so a same-cycle commit is not visible yet.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == AXI_IDX_W'(i)) rd_data = regs_q[i];
        end
    end

    assign regs_o = regs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= {NUM_REGS{RESET_VAL}};
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            regs_q <= regs_d;

            if (aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axi.aw_addr;
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end

            if (w_hs) begin
                w_held_q <= 1'b1;
                w_data_q <= s_axi.w_data;
                w_strb_q <= s_axi.w_strb;
            end else if (commit) begin
                w_held_q <= 1'b0;
            end

            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                b_valid_q <= 1'b0;
                b_resp_q  <= RESP_OKAY;
            end

            if (ar_hs) begin
                r_valid_q <= 1'b1;
                r_data_q  <= ar_in_range ? rd_data : '0;
                r_resp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (r_hs) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_resp_q  <= RESP_OKAY;
            end
        end
    end

endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- Terminal AXI-Lite slave that sits directly downstream of the 1x1 bridge. It consumes the bridge's slave-side interface and implements a bank of NUM_REGS 32-bit control/status registers.
- Write and read channels are decoupled: AW and W are accepted independently, B is generated once both have been captured, and AR/R form a one-deep read pipeline.
- The register contents and per-register write pulses are exported to the surrounding logic.

Parameters:
- ADDR_WIDTH, 8, byte-address width carried on aw_addr/ar_addr.
- DATA_WIDTH, 32, data width; fixed at 32 (4 strobe bits).
- NUM_REGS, 4, number of registers; the word index is addr[ADDR_WIDTH-1:2].
- RESET_VAL, 32'h0, reset value loaded into every register.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_axi  axi_lite_if.slave  -  AXI-Lite slave modport carrying the AW, W, B, AR and R channels.
- regs_o  output  NUM_REGS*DATA_WIDTH  current register contents; register i occupies bits [32i+31:32i].
- wr_pulse_o  output  NUM_REGS  one-cycle pulse on bit i in the cycle register i is committed.

Behaviour:
- Reset (rst sampled high at an edge):
  - All registers go to RESET_VAL.
  - aw_held, w_held, b_valid, r_valid and wr_pulse_o all clear.
  - b_resp = 2'b00, r_resp = 2'b00, r_data = 0.
  - aw_ready, w_ready and ar_ready are forced low combinationally while rst is high.
- Write address capture:
  - aw_ready = !aw_held && !rst.
  - When aw_valid && aw_ready, latch aw_addr and set aw_held.
- Write data capture:
  - w_ready = !w_held && !rst.
  - When w_valid && w_ready, latch w_data and w_strb and set w_held.
- AW and W may arrive in either order or in the same cycle; no ordering is imposed.
- Commit:
  - Condition: aw_held && w_held && !b_valid in cycle C.
  - If the index is below NUM_REGS, byte lane k of the register updates only where strb[k]=1. The register value changes at the end of C.
  - wr_pulse_o[idx] is high during C for an in-range commit.
  - aw_held and w_held clear at the end of C. b_valid goes high in C+1.
- Response code: b_resp = 2'b00 (OKAY) for an in-range index; 2'b10 (SLVERR) for out of range, in which case no register changes and no pulse is issued.
- Minimum write latency: AW and W handshake in cycle T -> commit in T+1 -> b_valid in T+2.
- B hold: b_valid and b_resp stay stable until b_ready, and clear on the edge where b_valid && b_ready.
  - While b_valid is high, a new AW and W may each still be captured once, since aw_held and w_held are free.
  - The next commit waits until b_valid is low.
- Unaligned addresses: addr[1:0] is ignored and never causes an error.
- Read channel:
  - ar_ready = !r_valid && !rst.
  - On an ar handshake in cycle T: r_valid goes high in T+1, and r_data holds the register value as sampled at the end of T (the pre-write value if a commit occurs in the same cycle T).
  - Out-of-range read: r_data = 0, r_resp = SLVERR.
  - r_valid, r_data and r_resp stay stable until r_ready and clear on the handshake edge, giving a maximum read throughput of one per two cycles.
- Independence: the read and write paths share no state except the register array. Reads are never stalled by writes.
- Reset mid-transaction: pending held AW/W data and any pending B or R are discarded, with no response issued.
- Protocol compliance: valid is never dropped before its handshake, and ready never depends combinationally on valid.

Decomposition:
- Add to axi_lite_pkg:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - The axi_lite_resp_t typedef.
  - A function addr_to_idx(addr) that returns addr[ADDR_WIDTH-1:2].
- No sub-module. The holding registers, commit logic and read pipeline are implemented flat, at roughly 150-200 lines.

Test Plan:
- Reset then idle: after rst is deasserted, regs_o = 0, aw_ready, w_ready and ar_ready are all 1, and b_valid = r_valid = 0.
- Write 0xDEADBEEF to address 0x04 with strb 4'hF, AW and W in the same cycle T:
  - wr_pulse_o = 4'b0010 in T+1.
  - regs_o[63:32] = 0xDEADBEEF.
  - b_valid in T+2 with b_resp 00.
- Partial-strobe write in the opposite order (W first with 0x11223344 and strb 4'b0101, AW for address 0x08 three cycles later), with reg2 previously 0xAAAAAAAA -> reg2 = 0xAA22AA44 and OKAY.
- Out-of-range write to 0x10 (NUM_REGS=4) -> b_resp = 10, all registers unchanged, wr_pulse_o stays 0.
- Read 0x04 while holding r_ready low for 5 cycles -> r_data = 0xDEADBEEF stays stable with r_valid high and ar_ready = 0 throughout. Read 0x0C -> OKAY. Read 0x14 -> data 0 with SLVERR.
- Backpressure and reset:
  - With b_ready held low, a second AW/W pair is captured but not committed. aw_ready and w_ready drop, and wr_pulse_o stays 0 until b_ready is raised.
  - Asserting rst with an AW held clears everything, and no B is ever produced.
